// File: rtl/lab03_pkg.sv
// Shared types for the lab03 bit-serial comparator: FSM states, one-hot verdicts, width helper.
// No logic here; no latency or flow control of its own.
package lab03_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One-hot verdict codes, bit order {gt, eq, lt}
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab03_cmp_sequencer_if.sv
// Operand/verdict bundle between the input stage and the comparator sequencer.
// start is a request sampled only when the sequencer is idle; nothing is queued.
interface lab03_cmp_sequencer_if #(
  parameter int N = 4
);
  import lab03_pkg::*;

  localparam int BW = cnt_width(N);

  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [BW-1:0] bits_used;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt, bits_used
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt, bits_used
  );

endinterface

// File: rtl/lab03_bit_cmp.sv
// Single-bit magnitude compare cell; purely combinational, zero latency.
// No flow control: outputs follow inputs.
module lab03_bit_cmp (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/lab03_cmp_sequencer.sv
// Bit-serial MSB-first comparator; verdict N-k edges after accept (k = first differing bit), N if equal.
// start is ignored while busy and never queued; done pulses one cycle, verdict holds until next start.
module lab03_cmp_sequencer
  import lab03_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  lab03_cmp_sequencer_if.slave    bus
);

  localparam int IW = $clog2(N);
  localparam int BW = cnt_width(N);

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [IW-1:0] idx;
  logic [2:0]    verdict;
  logic [BW-1:0] bits_used;
  logic          busy;
  logic          done;
  logic          cell_gt;
  logic          cell_lt;

  // One shared cell walks the operands from MSB to LSB
  lab03_bit_cmp u_cell (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .gt (cell_gt),
    .lt (cell_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      verdict   <= '0;
      bits_used <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            idx       <= IW'(N - 1);
            verdict   <= '0;
            bits_used <= '0;
            busy      <= 1'b1;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          bits_used <= bits_used + BW'(1);
          if (cell_gt || cell_lt) begin
            verdict <= {cell_gt, 1'b0, cell_lt};
            done    <= 1'b1;
            state   <= DONE;
          end else if (idx == '0) begin
            verdict <= EQ;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.gt        = verdict[2];
  assign bus.eq        = verdict[1];
  assign bus.lt        = verdict[0];
  assign bus.bits_used = bits_used;

endmodule

// File: tb/tb_lab03_cmp_sequencer.sv
// Directed bench for the bit-serial comparator sequencer at N=4 plus a random N=8 sweep.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_lab03_cmp_sequencer;
  import lab03_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lab03_cmp_sequencer_if #(.N(4)) bus4 ();
  lab03_cmp_sequencer_if #(.N(8)) bus8 ();

  lab03_cmp_sequencer #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  lab03_cmp_sequencer #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a8;
    logic [7:0] b8;
    logic [2:0] exp_v;
    int         exp_bits;
    int         lat;
    int         dones;
    logic       got;

    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;

    // reset state
    #2;
    check("rst_busy", bus4.busy, 0);
    check("rst_done", bus4.done, 0);
    check("rst_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b000);
    check("rst_bits", bus4.bits_used, 0);
    check("rst_verdict8", {bus8.gt, bus8.eq, bus8.lt}, 3'b000);
    #10 rst = 1'b0;
    step();

    // 1010 vs 0110: MSB differs, gt after one bit
    bus4.a = 4'b1010; bus4.b = 4'b0110; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    check("t1_busy_t0", bus4.busy, 1);
    check("t1_done_t0", bus4.done, 0);
    step();
    check("t1_done", bus4.done, 1);
    check("t1_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b100);
    check("t1_bits", bus4.bits_used, 1);
    step();
    check("t1_busy_low", bus4.busy, 0);
    check("t1_done_low", bus4.done, 0);
    check("t1_hold", {bus4.gt, bus4.eq, bus4.lt}, 3'b100);

    // 0011 vs 0100, started in the first idle cycle after DONE
    bus4.a = 4'b0011; bus4.b = 4'b0100; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    check("t2_cleared", {bus4.gt, bus4.eq, bus4.lt}, 3'b000);
    check("t2_bits_clr", bus4.bits_used, 0);
    check("t2_busy", bus4.busy, 1);
    step();
    check("t2_done_early", bus4.done, 0);
    check("t2_bits1", bus4.bits_used, 1);
    step();
    check("t2_done", bus4.done, 1);
    check("t2_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b001);
    check("t2_bits", bus4.bits_used, 2);
    step();
    check("t2_busy_low", bus4.busy, 0);

    // equal operands: full scan, single done pulse
    bus4.a = 4'b0101; bus4.b = 4'b0101; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus4.done) dones++;
      if (i == 3) begin
        check("t3_done", bus4.done, 1);
        check("t3_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b010);
        check("t3_bits", bus4.bits_used, 4);
      end
    end
    check("t3_one_done", dones, 1);

    // start held during COMPARE with new operands must be ignored
    bus4.a = 4'b0100; bus4.b = 4'b0101; bus4.start = 1'b1;
    step();
    bus4.a = 4'b1111; bus4.b = 4'b0000;
    step();
    step();
    step();
    check("t4_done_early", bus4.done, 0);
    step();
    check("t4_done", bus4.done, 1);
    check("t4_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b001);
    check("t4_bits", bus4.bits_used, 4);
    bus4.start = 1'b0;
    step();
    check("t4_done_low", bus4.done, 0);
    check("t4_busy_low", bus4.busy, 0);
    step();
    step();
    check("t4_not_queued", bus4.busy, 0);
    check("t4_hold", {bus4.gt, bus4.eq, bus4.lt}, 3'b001);

    // asynchronous reset mid-compare
    bus4.a = 4'b0001; bus4.b = 4'b0000; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    step();
    step();
    check("t5_busy_pre", bus4.busy, 1);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_busy", bus4.busy, 0);
    check("t5_rst_done", bus4.done, 0);
    check("t5_rst_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b000);
    check("t5_rst_bits", bus4.bits_used, 0);
    #2 rst = 1'b0;
    step();
    check("t5_no_done", bus4.done, 0);
    check("t5_idle", bus4.busy, 0);
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    step();
    step();
    step();
    check("t5_done_early", bus4.done, 0);
    step();
    check("t5_done", bus4.done, 1);
    check("t5_verdict", {bus4.gt, bus4.eq, bus4.lt}, 3'b100);
    check("t5_bits", bus4.bits_used, 4);
    step();

    // N=8 random sweep
    for (int n = 0; n < 200; n++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = (n % 16 == 0) ? a8 : 8'($urandom_range(0, 255));
      exp_v = (a8 > b8) ? GT : ((a8 == b8) ? EQ : LT);
      exp_bits = 8;
      for (int i = 7; i >= 0; i--) begin
        if (a8[i] != b8[i]) begin
          exp_bits = 8 - i;
          break;
        end
      end
      bus8.a = a8; bus8.b = b8; bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        step();
        lat++;
        if (bus8.done) got = 1'b1;
      end
      check("sw_done_seen", got, 1);
      check("sw_latency", lat, exp_bits);
      check("sw_verdict", {bus8.gt, bus8.eq, bus8.lt}, exp_v);
      check("sw_bits", bus8.bits_used, exp_bits);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
